alu_issue_stage: RTL and testbench

- Upstream issue stage for the team's 3-bit-opcode, 4-bit-operand combinational ALU (5-bit result).
- Buffers incoming {sel, a, b} commands in a small FIFO.
- Drives registered, stable operands to the ALU for one full cycle, then captures the 5-bit result into an output register with a valid/ready handshake.
- Flags divide-by-zero and counts delivered results.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_issue_stage_if.sv | 26 ++
 rtl/alu_cmd_fifo.sv | 55 +++++
 rtl/alu_issue_stage.sv | 125 ++++++++++++
 tb/tb_alu_issue_stage.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, command layout,
// FSM state encoding and the divide-by-zero result value.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_LAND = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_NAND = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  localparam int CMD_W = 11;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [4:0] DZ_RESULT = 5'h1F;

  function automatic logic is_dz(input logic [2:0] sel, input logic [3:0] b);
    return (sel == OP_DIV) && (b == 4'd0);
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Command-in and result-out handshake bundle of the ALU issue stage.
interface alu_issue_stage_if;

  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_sel;
  logic [3:0] in_a;
  logic [3:0] in_b;

  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_y;
  logic [2:0] out_sel;
  logic       out_dz;

  modport slave (
    input  in_valid, in_sel, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y, out_sel, out_dz
  );

  modport master (
    output in_valid, in_sel, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y, out_sel, out_dz
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// DEPTH x W synchronous command FIFO; pushes while full are dropped,
// with no same-edge bypass from a simultaneous pop.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CMD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: contents are only observable through rptr/count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage for the 3-bit-opcode ALU: queues commands, presents stable
// operands for one cycle, then captures the result behind a valid/ready port.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_stage_if.slave   bus,
  output logic [2:0]         alu_sel,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  input  logic [4:0]         alu_y,
  output logic               busy,
  output logic [CNT_W-1:0]   done_cnt
);

  function automatic logic [4:0] dz_override(input logic dz, input logic [4:0] y);
    return dz ? DZ_RESULT : y;
  endfunction

  state_t     state, state_nxt;
  cmd_t       head;
  logic       fifo_full, fifo_empty;
  logic       pop, capture, deliver;

  logic [2:0] sel_p1;
  logic [3:0] a_p1, b_p1;
  logic [4:0] y_p2;
  logic [2:0] sel_p2;
  logic       dz_p2;
  logic       vld_p2;
  logic [CNT_W-1:0] cnt;

  alu_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.in_valid),
    .pop   (pop),
    .wdata ({bus.in_sel, bus.in_a, bus.in_b}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    deliver   = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (bus.out_ready) begin
        deliver = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: operands registered toward the ALU on every pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_p1 <= '0;
      a_p1   <= '0;
      b_p1   <= '0;
    end else if (pop) begin
      sel_p1 <= head.sel;
      a_p1   <= head.a;
      b_p1   <= head.b;
    end
  end

  // Stage p2: result register, loaded at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p2   <= '0;
      sel_p2 <= '0;
      dz_p2  <= 1'b0;
      vld_p2 <= 1'b0;
      cnt    <= '0;
    end else begin
      if (capture) begin
        y_p2   <= dz_override(is_dz(sel_p1, b_p1), alu_y);
        sel_p2 <= sel_p1;
        dz_p2  <= is_dz(sel_p1, b_p1);
        vld_p2 <= 1'b1;
      end else if (deliver) begin
        vld_p2 <= 1'b0;
      end
      if (deliver) cnt <= cnt + CNT_W'(1);
    end
  end

  assign alu_sel       = sel_p1;
  assign alu_a         = a_p1;
  assign alu_b         = b_p1;
  assign bus.in_ready  = !fifo_full;
  assign bus.out_valid = vld_p2;
  assign bus.out_y     = y_p2;
  assign bus.out_sel   = sel_p2;
  assign bus.out_dz    = dz_p2;
  assign busy          = !fifo_empty || (state != IDLE);
  assign done_cnt      = cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: models the ALU, keeps a queue of accepted
// commands as the reference and checks every delivered result against it.
module tb_alu_issue_stage;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] alu_sel;
  logic [3:0] alu_a, alu_b;
  logic [4:0] alu_y;
  logic busy;
  logic [CNT_W-1:0] done_cnt;

  alu_issue_stage_if bus ();

  alu_issue_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .alu_sel  (alu_sel),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_y    (alu_y),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  // Reference ALU; divide by zero returns an arbitrary junk value.
  function automatic logic [4:0] alu_ref(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: return (b == 4'd0) ? 5'h0A : {1'b0, a / b};
      3'd3: return {4'd0, (a != 4'd0) && (b != 4'd0)};
      3'd4: return {1'b0, a & b};
      3'd5: return {1'b0, a | b};
      3'd6: return {1'b0, ~(a & b)};
      default: return {1'b0, ~(a ^ b)};
    endcase
  endfunction

  function automatic logic [4:0] expect_y(input logic [10:0] c);
    if (c[10:8] == 3'd2 && c[3:0] == 4'd0) return 5'h1F;
    return alu_ref(c[10:8], c[7:4], c[3:0]);
  endfunction

  assign alu_y = alu_ref(alu_sel, alu_a, alu_b);

  int total = 0;
  int bad = 0;
  logic [10:0] q[$];
  logic [CNT_W-1:0] model_cnt = '0;
  int cyc = 0;
  int last_dlv_cyc = 0;
  int last_gap = 0;
  bit dlv_flag;
  logic [4:0] last_y;
  logic last_dz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already set for the coming posedge.
  task automatic tick(output bit acc);
    logic [10:0] c;
    acc = bus.in_valid && bus.in_ready;
    dlv_flag = 1'b0;
    if (bus.out_valid && bus.out_ready) begin
      dlv_flag = 1'b1;
      if (q.size() == 0) begin
        chk("spurious_delivery", 32'd1, 32'd0);
      end else begin
        c = q.pop_front();
        chk("out_y", 32'(bus.out_y), 32'(expect_y(c)));
        chk("out_sel", 32'(bus.out_sel), 32'(c[10:8]));
        chk("out_dz", 32'(bus.out_dz), 32'(c[10:8] == 3'd2 && c[3:0] == 4'd0));
      end
      last_y = bus.out_y;
      last_dz = bus.out_dz;
      model_cnt = model_cnt + 1'b1;
      last_gap = cyc - last_dlv_cyc;
      last_dlv_cyc = cyc;
    end
    if (acc) q.push_back({bus.in_sel, bus.in_a, bus.in_b});
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("done_cnt", 32'(done_cnt), 32'(model_cnt));
    chk("busy", 32'(busy), 32'(q.size() != 0));
  endtask

  task automatic push_cmd(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    bit acc;
    int n;
    bus.in_valid = 1'b1; bus.in_sel = s; bus.in_a = a; bus.in_b = b;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin tick(acc); n++; end
    chk("push_accept", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_dlv();
    bit acc;
    int n;
    n = 0;
    dlv_flag = 1'b0;
    while (!dlv_flag && n < 20) begin tick(acc); n++; end
    chk("delivery_seen", 32'(dlv_flag), 32'd1);
  endtask

  task automatic drain();
    bit acc;
    int n;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while ((busy || q.size() != 0) && n < 100) begin tick(acc); n++; end
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bit acc;
    logic [4:0] snap_y;
    logic [2:0] snap_sel, snap_alu_sel;
    logic snap_dz;
    logic [CNT_W-1:0] cnt_seq [5];
    logic [2:0] sels [6];

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_sel = '0; bus.in_a = '0; bus.in_b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_y", 32'(bus.out_y), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency and first add
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_sel = 3'd0; bus.in_a = 4'd4; bus.in_b = 4'd3;
    tick(acc);
    chk("t1_accept", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
    chk("t1_valid_e0", 32'(bus.out_valid), 32'd0);
    tick(acc);
    chk("t1_alu_a", 32'(alu_a), 32'd4);
    chk("t1_alu_b", 32'(alu_b), 32'd3);
    chk("t1_alu_sel", 32'(alu_sel), 32'd0);
    chk("t1_valid_e1", 32'(bus.out_valid), 32'd0);
    tick(acc);
    chk("t1_valid_e2", 32'(bus.out_valid), 32'd1);
    chk("t1_y", 32'(bus.out_y), 32'd7);
    chk("t1_sel", 32'(bus.out_sel), 32'd0);
    chk("t1_dz", 32'(bus.out_dz), 32'd0);
    tick(acc);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);

    // Subtract wrap, back-to-back throughput
    push_cmd(3'd1, 4'd3, 4'd4);
    push_cmd(3'd1, 4'd4, 4'd3);
    wait_dlv();
    chk("t2_y_wrap", 32'(last_y), 32'h1F);
    wait_dlv();
    chk("t2_y", 32'(last_y), 32'd1);
    chk("t2_gap", 32'(last_gap), 32'd2);

    // Divide by zero override
    push_cmd(3'd2, 4'd9, 4'd0);
    push_cmd(3'd2, 4'd9, 4'd2);
    wait_dlv();
    chk("t3_dz_y", 32'(last_y), 32'h1F);
    chk("t3_dz", 32'(last_dz), 32'd1);
    wait_dlv();
    chk("t3_y", 32'(last_y), 32'd4);
    chk("t3_nodz", 32'(last_dz), 32'd0);
    drain();

    // Backpressure: FIFO fills, HOLD outputs stay put
    sels[0] = 3'd4; sels[1] = 3'd5; sels[2] = 3'd6;
    sels[3] = 3'd7; sels[4] = 3'd0; sels[5] = 3'd1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(sels[i], 4'd4, 4'd3);
    chk("t4_full", 32'(bus.in_ready), 32'd0);
    chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
    snap_y = bus.out_y; snap_sel = bus.out_sel; snap_dz = bus.out_dz;
    snap_alu_sel = alu_sel;
    bus.in_valid = 1'b1; bus.in_sel = sels[5]; bus.in_a = 4'd4; bus.in_b = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      chk("t4_blocked", 32'(acc), 32'd0);
      chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
      chk("t4_stable_y", 32'(bus.out_y), 32'(snap_y));
      chk("t4_stable_sel", 32'(bus.out_sel), 32'(snap_sel));
      chk("t4_stable_dz", 32'(bus.out_dz), 32'(snap_dz));
      chk("t4_stable_alu", 32'(alu_sel), 32'(snap_alu_sel));
    end
    bus.out_ready = 1'b1;
    begin
      int n;
      n = 0; acc = 1'b0;
      while (!acc && n < 20) begin tick(acc); n++; end
      chk("t4_sixth_accept", 32'(acc), 32'd1);
    end
    drain();

    // Asynchronous reset while in EXEC with three commands queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(3'(i), 4'(i + 1), 4'd2);
    bus.out_ready = 1'b1;
    tick(acc);
    chk("t5_exec_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    q.delete();
    model_cnt = '0;
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_out_y", 32'(bus.out_y), 32'd0);
    chk("t5_out_sel", 32'(bus.out_sel), 32'd0);
    chk("t5_alu_a", 32'(alu_a), 32'd0);
    chk("t5_alu_b", 32'(alu_b), 32'd0);
    chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done_cnt", 32'(done_cnt), 32'd0);
    tick(acc);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(acc);
      chk("t5_quiet", 32'(bus.out_valid), 32'd0);
    end

    // Delivered-result counter wraps at 2^CNT_W
    cnt_seq[0] = 2'd1; cnt_seq[1] = 2'd2; cnt_seq[2] = 2'd3;
    cnt_seq[3] = 2'd0; cnt_seq[4] = 2'd1;
    for (int i = 0; i < 5; i++) begin
      push_cmd(3'd5, 4'(i), 4'd8);
      wait_dlv();
      chk("t6_cnt", 32'(done_cnt), 32'(cnt_seq[i]));
    end

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_sel    = 3'($urandom_range(0, 7));
      bus.in_a      = 4'($urandom_range(0, 15));
      bus.in_b      = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
